// File: rtl/seven_segment_scan_reader_if.sv
// Bus bundle for the seven-segment scan reader: the sampled display lines in, recovered digits and pulses out.
// The display side (master) drives segments/anodes; the reader (slave) drives results and debug state.
interface seven_segment_scan_reader_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    segment_a_i;
  logic                    segment_b_i;
  logic                    segment_c_i;
  logic                    segment_d_i;
  logic                    segment_e_i;
  logic                    segment_f_i;
  logic                    segment_g_i;
  logic [NUM_DIGITS-1:0]   anode_i;
  logic [4*NUM_DIGITS-1:0] digits_o;
  logic [NUM_DIGITS-1:0]   digit_valid_o;
  logic                    frame_valid_o;
  logic                    pattern_err_o;
  logic [7:0]              dbg_cnt;
  logic                    dbg_captured;

  modport master (
    output segment_a_i, segment_b_i, segment_c_i, segment_d_i,
           segment_e_i, segment_f_i, segment_g_i, anode_i,
    input  digits_o, digit_valid_o, frame_valid_o, pattern_err_o,
           dbg_cnt, dbg_captured
  );

  modport slave (
    input  segment_a_i, segment_b_i, segment_c_i, segment_d_i,
           segment_e_i, segment_f_i, segment_g_i, anode_i,
    output digits_o, digit_valid_o, frame_valid_o, pattern_err_o,
           dbg_cnt, dbg_captured
  );
endinterface

// File: rtl/seven_segment_scan_reader.sv
// Recovers hex digits from a multiplexed seven-segment bus, flags illegal patterns, pulses per full frame.
// Optional macro SEVEN_SEGMENT_READER_ACTIVE_HIGH_EN: treat segment/anode inputs as active-high.
module seven_segment_scan_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input logic clk_i,
  input logic rst_i,
  seven_segment_scan_reader_if.slave bus
);
  localparam int                    W        = NUM_DIGITS + 7;
  localparam logic [7:0]            CAP_CNT  = 8'(STABLE_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

  logic [W-1:0]            raw, sync1, sync2, s_val, p_val;
  logic [7:0]              cnt, cnt_inc;
  logic                    captured;
  logic [NUM_DIGITS-1:0]   seen, anode_low;
  logic [4*NUM_DIGITS-1:0] digits_r;
  logic [NUM_DIGITS-1:0]   valid_r;
  logic                    frame_r, err_r;
  logic                    active, stable;
  logic [3:0]              dec_val;
  logic                    dec_ok;

  assign raw = {bus.anode_i, bus.segment_a_i, bus.segment_b_i, bus.segment_c_i,
                bus.segment_d_i, bus.segment_e_i, bus.segment_f_i, bus.segment_g_i};

`ifdef SEVEN_SEGMENT_READER_ACTIVE_HIGH_EN
  assign s_val = ~sync2;
`else
  assign s_val = sync2;
`endif

  // anode_low is the one-hot "digit selected" vector when exactly one anode is driven low
  assign anode_low = ~s_val[W-1:7];
  assign active    = $onehot(anode_low);
  assign stable    = active && (s_val == p_val);
  assign cnt_inc   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'h0;
    case (s_val[6:0])
      7'b0000001: dec_val = 4'h0;
      7'b1001111: dec_val = 4'h1;
      7'b0010010: dec_val = 4'h2;
      7'b0000110: dec_val = 4'h3;
      7'b1001100: dec_val = 4'h4;
      7'b0100100: dec_val = 4'h5;
      7'b0100000: dec_val = 4'h6;
      7'b0001111: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0000100: dec_val = 4'h9;
      7'b0001000: dec_val = 4'hA;
      7'b1100000: dec_val = 4'hB;
      7'b0110001: dec_val = 4'hC;
      7'b1000010: dec_val = 4'hD;
      7'b0110000: dec_val = 4'hE;
      7'b0111000: dec_val = 4'hF;
      default:    dec_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1    <= '0;
      sync2    <= '0;
      p_val    <= '0;
      cnt      <= 8'd0;
      captured <= 1'b0;
      seen     <= '0;
      digits_r <= '0;
      valid_r  <= '0;
      frame_r  <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      p_val   <= s_val;
      frame_r <= 1'b0;
      err_r   <= 1'b0;
      if (!stable) begin
        cnt      <= 8'd0;
        captured <= 1'b0;
      end else begin
        cnt <= cnt_inc;
        // captured flag guarantees one capture per dwell even after saturation
        if (cnt_inc == CAP_CNT && !captured) begin
          captured <= 1'b1;
          err_r    <= !dec_ok;
          for (int k = 0; k < NUM_DIGITS; k++) begin
            if (anode_low[k]) begin
              if (dec_ok) digits_r[4*k +: 4] <= dec_val;
              valid_r[k] <= dec_ok;
            end
          end
          if ((seen | anode_low) == ALL_SEEN) begin
            frame_r <= 1'b1;
            seen    <= '0;
          end else begin
            seen <= seen | anode_low;
          end
        end
      end
    end
  end

  assign bus.digits_o      = digits_r;
  assign bus.digit_valid_o = valid_r;
  assign bus.frame_valid_o = frame_r;
  assign bus.pattern_err_o = err_r;
  assign bus.dbg_cnt       = cnt;
  assign bus.dbg_captured  = captured;
endmodule

// File: tb/tb_seven_segment_scan_reader.sv
// Bench for seven_segment_scan_reader: directed scenarios plus random dwells checked cycle by cycle
// against a run-length reference model (capture reported two edges after the dwell reaches its length).
module tb_seven_segment_scan_reader;
  localparam int ND = 4;
  localparam int ST = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  seven_segment_scan_reader_if #(.NUM_DIGITS(ND)) bus ();

  seven_segment_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(ST)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // active-low abcdefg patterns for hex 0..F
  logic [6:0] seg_tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int n_vec  = 0;
  int n_miss = 0;
  int frame_cnt = 0;
  int err_cnt   = 0;

  // reference model state
  logic [15:0] e_digits = '0;
  logic [3:0]  e_valid  = '0;
  logic [3:0]  e_seen   = '0;
  logic        e_frame  = 1'b0;
  logic        e_err    = 1'b0;
  logic [10:0] run_val  = '0;
  int          run_len  = 0;
  logic [11:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [10:0] x);
    logic [11:0] due;
    int k;
    int v;
    e_frame = 1'b0;
    e_err   = 1'b0;
    if (r) begin
      e_digits = '0;
      e_valid  = '0;
      e_seen   = '0;
      run_len  = 0;
      exp_q.delete();
      exp_q.push_back('0);
      exp_q.push_back('0);
      return;
    end
    if ($countones(~x[10:7]) == 1) begin
      if (run_len > 0 && x == run_val) run_len++;
      else begin
        run_val = x;
        run_len = 1;
      end
    end else begin
      run_len = 0;
    end
    due = exp_q.pop_front();
    exp_q.push_back({run_len == ST, x});
    if (due[11]) begin
      k = 0;
      v = -1;
      for (int i = 0; i < ND; i++) if (!due[7+i]) k = i;
      for (int i = 0; i < 16; i++) if (seg_tbl[i] == due[6:0]) v = i;
      if (v >= 0) begin
        e_digits[4*k +: 4] = 4'(v);
        e_valid[k] = 1'b1;
      end else begin
        e_valid[k] = 1'b0;
        e_err = 1'b1;
      end
      e_seen[k] = 1'b1;
      if (e_seen == 4'hF) begin
        e_frame = 1'b1;
        e_seen  = '0;
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] an, input logic [6:0] seg);
    @(negedge clk_i);
    rst_i = r;
`ifdef SEVEN_SEGMENT_READER_ACTIVE_HIGH_EN
    bus.anode_i = ~an;
    {bus.segment_a_i, bus.segment_b_i, bus.segment_c_i, bus.segment_d_i,
     bus.segment_e_i, bus.segment_f_i, bus.segment_g_i} = ~seg;
`else
    bus.anode_i = an;
    {bus.segment_a_i, bus.segment_b_i, bus.segment_c_i, bus.segment_d_i,
     bus.segment_e_i, bus.segment_f_i, bus.segment_g_i} = seg;
`endif
    @(posedge clk_i);
    #1;
    model_step(r, {an, seg});
    check("digits", 32'(bus.digits_o), 32'(e_digits));
    check("digit_valid", 32'(bus.digit_valid_o), 32'(e_valid));
    check("frame_valid", 32'(bus.frame_valid_o), 32'(e_frame));
    check("pattern_err", 32'(bus.pattern_err_o), 32'(e_err));
    if (bus.frame_valid_o) frame_cnt++;
    if (bus.pattern_err_o) err_cnt++;
  endtask

  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int len);
    for (int i = 0; i < len; i++) step(1'b0, an, seg);
  endtask

  logic [15:0] snap_digits;
  logic [3:0]  snap_valid;

  initial begin
    bus.anode_i = '1;
    {bus.segment_a_i, bus.segment_b_i, bus.segment_c_i, bus.segment_d_i,
     bus.segment_e_i, bus.segment_f_i, bus.segment_g_i} = '1;

    for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 7'h7F);

    // single stable digit, one capture
    err_cnt = 0; frame_cnt = 0;
    dwell(4'b1110, 7'b0000110, 20);
    check("d0_value", 32'(bus.digits_o[3:0]), 32'h3);
    check("d0_valid", 32'(bus.digit_valid_o), 32'b0001);
    check("d0_pulses", 32'(err_cnt + frame_cnt), 32'd0);

    // full scan 1, A, 0, F
    frame_cnt = 0;
    dwell(4'b1110, seg_tbl[1], 12);
    dwell(4'b1101, seg_tbl[10], 12);
    dwell(4'b1011, seg_tbl[0], 12);
    dwell(4'b0111, seg_tbl[15], 12);
    check("scan_digits", 32'(bus.digits_o), 32'hF0A1);
    check("scan_valid", 32'(bus.digit_valid_o), 32'hF);
    check("scan_frames", 32'(frame_cnt), 32'd1);

    // illegal pattern on digit 2
    err_cnt = 0;
    dwell(4'b1011, 7'b1111111, 12);
    check("illegal_errs", 32'(err_cnt), 32'd1);
    check("illegal_hold", 32'(bus.digits_o[11:8]), 32'h0);
    check("illegal_valid", 32'(bus.digit_valid_o[2]), 32'd0);

    // glitching segments and non-one-hot anodes
    snap_digits = e_digits; snap_valid = e_valid;
    err_cnt = 0; frame_cnt = 0;
    for (int g = 0; g < 6; g++) dwell(4'b1110, seg_tbl[g], 5);
    dwell(4'b1100, seg_tbl[4], 20);
    dwell(4'b1111, seg_tbl[4], 20);
    check("glitch_digits", 32'(bus.digits_o), 32'(snap_digits));
    check("glitch_valid", 32'(bus.digit_valid_o), 32'(snap_valid));
    check("glitch_pulses", 32'(err_cnt + frame_cnt), 32'd0);

    // reset in the middle of a dwell
    dwell(4'b1101, seg_tbl[5], 7);
    step(1'b1, 4'b1101, seg_tbl[5]);
    check("midrst_digits", 32'(bus.digits_o), 32'h0);
    check("midrst_valid", 32'(bus.digit_valid_o), 32'h0);
    dwell(4'b1101, seg_tbl[5], 12);
    check("midrst_recap", 32'(bus.digits_o[7:4]), 32'h5);
    check("midrst_vmask", 32'(bus.digit_valid_o), 32'b0010);

    // very long dwell: saturation, still one capture
    err_cnt = 0; frame_cnt = 0;
    dwell(4'b0111, seg_tbl[8], 300);
    check("long_value", 32'(bus.digits_o[15:12]), 32'h8);
    check("long_pulses", 32'(err_cnt + frame_cnt), 32'd0);

    // random dwells
    for (int n = 0; n < 300; n++) begin
      int k, mode, len, gl;
      logic [3:0] an;
      logic [6:0] seg, s;
      k = $urandom_range(0, ND-1);
      an = 4'hF;
      an[k] = 1'b0;
      mode = $urandom_range(0, 9);
      len = $urandom_range(1, 16);
      gl = $urandom_range(0, 3);
      seg = seg_tbl[$urandom_range(0, 15)];
      if (mode == 7) seg = 7'($urandom_range(0, 127));
      if (mode == 8) an = 4'($urandom_range(0, 15));
      if (mode == 9) step(1'b1, an, seg);
      for (int i = 0; i < len; i++) begin
        s = seg;
        if (gl == 0 && i == len/2) s = seg ^ 7'(1 << $urandom_range(0, 6));
        step(1'b0, an, s);
      end
    end
    dwell(4'hF, 7'h7F, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
